spi_responder: RTL and testbench

- SPI mode-0 responder (slave) peripheral on the j1a I/O bus.
- Lets an external SPI host exchange bytes with the CPU over PMOD pins, the opposite role to the CPU's bit-banged flash master.
- CPU side follows the UART handshake:
  - `rd` consumes a received byte;
  - `wr` queues a transmit byte;
  - `valid` and `busy` are polled as status bits.

---
 rtl/spi_responder.sv | 103 ++++++++++
 tb/tb_spi_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder on the j1a I/O bus with UART-style rd/wr/valid/busy handshake; ports clk, reset, sck, cs_n, mosi, miso, miso_oe, rd, wr, tx_data, rx_data, valid, busy, overrun; define SPI_RESP_DONE_EN to add a done pulse on each cs_n rise
module spi_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sck,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic       rd,
   input  logic       wr,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       valid,
   output logic       busy,
   output logic       overrun
`ifdef SPI_RESP_DONE_EN
   ,
   output logic       done
`endif
);
   logic [SYNC_STAGES-1:0] sck_s, cs_s, mosi_s;
   logic sck_p, cs_p;
   logic [2:0] cnt;
   logic [7:0] in_sr, out_sr, hold;
   logic sck_c, cs_c, mosi_c, active, sck_rise, sck_fall, cs_fall, cs_rise, load;
   logic [7:0] in_next;
   assign sck_c    = sck_s[SYNC_STAGES-1];
   assign cs_c     = cs_s[SYNC_STAGES-1];
   assign mosi_c   = mosi_s[SYNC_STAGES-1];
   assign active   = ~cs_c;
   assign sck_rise = sck_c & ~sck_p;
   assign sck_fall = ~sck_c & sck_p;
   assign cs_fall  = ~cs_c & cs_p;
   assign cs_rise  = cs_c & ~cs_p;
   assign load     = cs_fall | (active & sck_fall & cnt == 3'd0);
   assign in_next  = {in_sr[6:0], mosi_c};
   assign miso     = out_sr[7];
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_s   <= '0;
         cs_s    <= '1;
         mosi_s  <= '0;
         sck_p   <= 1'b0;
         cs_p    <= 1'b1;
         cnt     <= 3'd0;
         in_sr   <= 8'd0;
         out_sr  <= 8'd0;
         hold    <= 8'd0;
         miso_oe <= 1'b0;
         rx_data <= 8'd0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         overrun <= 1'b0;
`ifdef SPI_RESP_DONE_EN
         done    <= 1'b0;
`endif
      end else begin
         sck_s   <= {sck_s[SYNC_STAGES-2:0], sck};
         cs_s    <= {cs_s[SYNC_STAGES-2:0], cs_n};
         mosi_s  <= {mosi_s[SYNC_STAGES-2:0], mosi};
         sck_p   <= sck_c;
         cs_p    <= cs_c;
         miso_oe <= active;
         // the shifter takes the pre-wr holding value; a same-cycle wr re-queues below
         if (load) begin
            out_sr <= busy ? hold : IDLE_BYTE;
            busy   <= 1'b0;
         end else if (active & sck_fall)
            out_sr <= {out_sr[6:0], 1'b0};
         if (wr) begin
            hold <= tx_data;
            busy <= 1'b1;
         end
         if (rd) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end
         if (!active)
            cnt <= 3'd0;
         else if (sck_rise) begin
            in_sr <= in_next;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
               rx_data <= in_next;
               valid   <= 1'b1;
               if (valid & ~rd)
                  overrun <= 1'b1;
            end
         end
`ifdef SPI_RESP_DONE_EN
         done <= cs_rise;
`endif
      end
   end
`ifndef SPI_RESP_DONE_EN
   logic unused_cs_rise;
   assign unused_cs_rise = cs_rise;
`endif
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed self-checking bench for spi_responder driving a mode-0 host at clk/8
module tb_spi_responder;
   logic clk = 1'b0, reset = 1'b1, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [7:0] tx_data = 8'd0;
   logic miso, miso_oe, valid, busy, overrun;
   logic [7:0] rx_data;
   int n_chk = 0, n_fail = 0;
`ifdef SPI_RESP_DONE_EN
   logic done;
   int done_cycles = 0;
   always @(posedge clk) if (done) done_cycles++;
`endif
   spi_responder dut (
      .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .rd(rd), .wr(wr), .tx_data(tx_data),
      .rx_data(rx_data), .valid(valid), .busy(busy), .overrun(overrun)
`ifdef SPI_RESP_DONE_EN
      , .done(done)
`endif
   );
   always #5 clk = ~clk;
   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_wr(input logic [7:0] d);
      @(negedge clk); wr = 1'b1; tx_data = d;
      @(negedge clk); wr = 1'b0;
   endtask
   task automatic do_rd();
      @(negedge clk); rd = 1'b1;
      @(negedge clk); rd = 1'b0;
   endtask
   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'd0;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         clks(4);
         rx[7-i] = miso;
         sck = 1'b1;
         clks(4);
         sck = 1'b0;
      end
      clks(4);
   endtask
   task automatic cs_low();
      @(negedge clk); cs_n = 1'b0;
      clks(6);
   endtask
   task automatic cs_high();
      @(negedge clk); cs_n = 1'b1;
      clks(6);
   endtask
   task automatic test_reset();
      reset = 1'b1; clks(3); reset = 1'b0; clks(1);
      n_chk++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", miso); end
      n_chk++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe got %b want 0", miso_oe); end
      n_chk++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
      do_wr(8'h5A);
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_sets_busy got %b want 1", busy); end
      @(negedge clk); reset = 1'b1; clks(1); reset = 1'b0; clks(1);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_clears_busy got %b want 0", busy); end
   endtask
   task automatic test_basic();
      logic [7:0] r;
      do_wr(8'hA5);
      cs_low();
      n_chk++; if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL basic_miso_oe got %b want 1", miso_oe); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after_load got %b want 0", busy); end
      xfer(8'h3C, 8, r);
      cs_high();
      n_chk++; if (r !== 8'hA5) begin n_fail++; $display("FAIL basic_host_rx got %h want a5", r); end
      n_chk++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL basic_rx_data got %h want 3c", rx_data); end
      n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", valid); end
      n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun got %b want 0", overrun); end
      n_chk++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL basic_miso_oe_off got %b want 0", miso_oe); end
   endtask
   task automatic test_idle();
      logic [7:0] r;
      do_rd();
      n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL idle_rd_clears_valid got %b want 0", valid); end
      cs_low(); xfer(8'h11, 8, r); cs_high();
      n_chk++; if (r !== 8'hFF) begin n_fail++; $display("FAIL idle_host_rx got %h want ff", r); end
      n_chk++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL idle_rx_data got %h want 11", rx_data); end
      n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL idle_valid got %b want 1", valid); end
   endtask
   task automatic test_overrun();
      logic [7:0] r;
      do_rd();
      cs_low(); xfer(8'h01, 8, r);
      n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first_byte got %b want 0", overrun); end
      xfer(8'h02, 8, r); cs_high();
      n_chk++; if (rx_data !== 8'h02) begin n_fail++; $display("FAIL ovr_rx_data got %h want 02", rx_data); end
      n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", overrun); end
      do_rd();
      n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_rd_valid got %b want 0", valid); end
      n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_rd_overrun got %b want 0", overrun); end
   endtask
   task automatic test_back_to_back();
      logic [7:0] r1, r2;
      do_wr(8'h55);
      cs_low();
      fork
         xfer(8'h00, 8, r1);
         begin clks(20); do_wr(8'hC3); end
      join
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_byte1 got %b want 0", busy); end
      xfer(8'h00, 8, r2); cs_high();
      n_chk++; if (r1 !== 8'h55) begin n_fail++; $display("FAIL b2b_host_rx1 got %h want 55", r1); end
      n_chk++; if (r2 !== 8'hC3) begin n_fail++; $display("FAIL b2b_host_rx2 got %h want c3", r2); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got %b want 0", busy); end
      do_rd();
   endtask
   task automatic test_overwrite();
      logic [7:0] r;
      do_wr(8'h12); do_wr(8'h34);
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovw_busy got %b want 1", busy); end
      cs_low(); xfer(8'h00, 8, r); cs_high();
      n_chk++; if (r !== 8'h34) begin n_fail++; $display("FAIL ovw_host_rx got %h want 34", r); end
      do_rd();
   endtask
   task automatic test_abort();
      logic [7:0] r;
      int k;
`ifdef SPI_RESP_DONE_EN
      int d0;
      d0 = done_cycles;
`endif
      cs_low(); xfer(8'h77, 8, r); cs_high();
`ifdef SPI_RESP_DONE_EN
      n_chk++; if (done_cycles - d0 !== 1) begin n_fail++; $display("FAIL done_full_frame got %0d want 1", done_cycles - d0); end
      d0 = done_cycles;
`endif
      cs_low(); xfer(8'hF0, 5, r);
      n_chk++; if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL abort_oe_before got %b want 1", miso_oe); end
      @(negedge clk); cs_n = 1'b1;
      k = 0;
      while (miso_oe === 1'b1 && k < 3) begin @(negedge clk); k++; end
      n_chk++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL abort_oe_drop got %b want 0 within 3 clks", miso_oe); end
      clks(6);
      n_chk++; if (rx_data !== 8'h77) begin n_fail++; $display("FAIL abort_rx_data got %h want 77", rx_data); end
      n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL abort_valid got %b want 1", valid); end
`ifdef SPI_RESP_DONE_EN
      n_chk++; if (done_cycles - d0 !== 1) begin n_fail++; $display("FAIL done_abort got %0d want 1", done_cycles - d0); end
`endif
      do_rd();
      cs_low(); xfer(8'h9A, 8, r); cs_high();
      n_chk++; if (rx_data !== 8'h9A) begin n_fail++; $display("FAIL abort_next_rx got %h want 9a", rx_data); end
      n_chk++; if (r !== 8'hFF) begin n_fail++; $display("FAIL abort_next_host_rx got %h want ff", r); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_idle();
      test_overrun();
      test_back_to_back();
      test_overwrite();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
